// File: rtl/spi_master.sv
// spi_master: single-clock SPI initiator for the SPI slave/RAM wrapper.
// A frame is one select bit (cmd[1]) followed by the 10-bit {cmd, wr_data}
// word, MSB first, one bit per clk with SS_n low. Read-data frames (cmd=11)
// then wait TURN idle cycles and capture an 8-bit reply from MISO.
//
// State table:
//   ST_IDLE  | SS_n high, waiting for start
//   ST_SEL   | select bit (cmd[1]) on MOSI
//   ST_SHIFT | 10 frame bits on MOSI, MSB first
//   ST_TURN  | TURN idle cycles before the reply (cmd=11 only)
//   ST_CAPT  | 8 MISO samples, MSB first
//   ST_END   | SS_n high for GAP cycles; done/rd_valid in the first one
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     frame request, honoured only while busy=0
//   cmd       00 wr addr, 01 wr data, 10 rd addr, 11 rd data
//   wr_data   frame payload
//   busy      frame in progress, including the GAP cycles
//   done      one-cycle pulse as SS_n returns high
//   rd_data   last byte captured on a cmd=11 frame
//   rd_valid  one-cycle pulse with done on cmd=11 frames
//   MOSI      serial data to slave
//   SS_n      slave select, active-low
//   MISO      serial data from slave
module spi_master #(
    parameter int unsigned TURN = 2,
    parameter int unsigned GAP  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       MOSI,
    output logic       SS_n,
    input  logic       MISO
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_SHIFT,
        ST_TURN,
        ST_CAPT,
        ST_END
    } state_t;

    state_t      state;
    logic [9:0]  frame;
    logic [1:0]  cmd_q;
    logic [3:0]  bit_cnt;
    logic [2:0]  tmr;
    logic [2:0]  cap_cnt;
    logic [7:0]  shreg;

    // Outputs are loaded one edge ahead, alongside the state they belong to,
    // so every output is a plain flop with no path from start or MISO.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            frame    <= '0;
            cmd_q    <= '0;
            bit_cnt  <= '0;
            tmr      <= '0;
            cap_cnt  <= '0;
            shreg    <= '0;
            rd_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            MOSI     <= 1'b0;
            SS_n     <= 1'b1;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    SS_n <= 1'b1;
                    MOSI <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        frame <= {cmd, wr_data};
                        cmd_q <= cmd;
                        state <= ST_SEL;
                        SS_n  <= 1'b0;
                        MOSI  <= cmd[1];
                        busy  <= 1'b1;
                    end
                end
                ST_SEL: begin
                    state   <= ST_SHIFT;
                    bit_cnt <= 4'd9;
                    MOSI    <= frame[9];
                end
                ST_SHIFT: begin
                    // bit_cnt indexes the bit currently on MOSI
                    if (bit_cnt == 4'd0) begin
                        MOSI <= 1'b0;
                        if (cmd_q == 2'b11) begin
                            state <= ST_TURN;
                            tmr   <= 3'(TURN - 1);
                        end else begin
                            state <= ST_END;
                            SS_n  <= 1'b1;
                            done  <= 1'b1;
                            tmr   <= 3'(GAP - 1);
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 4'd1;
                        MOSI    <= frame[bit_cnt - 4'd1];
                    end
                end
                ST_TURN: begin
                    if (tmr == 3'd0) begin
                        state   <= ST_CAPT;
                        cap_cnt <= 3'd7;
                    end else begin
                        tmr <= tmr - 3'd1;
                    end
                end
                ST_CAPT: begin
                    shreg <= {shreg[6:0], MISO};
                    if (cap_cnt == 3'd0) begin
                        rd_data  <= {shreg[6:0], MISO};
                        state    <= ST_END;
                        SS_n     <= 1'b1;
                        done     <= 1'b1;
                        rd_valid <= 1'b1;
                        tmr      <= 3'(GAP - 1);
                    end else begin
                        cap_cnt <= cap_cnt - 3'd1;
                    end
                end
                ST_END: begin
                    if (tmr == 3'd0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        tmr <= tmr - 3'd1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    SS_n  <= 1'b1;
                    MOSI  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed bench for spi_master with a small behavioural
// slave/RAM model on MOSI/SS_n/MISO. A second instance with GAP=2 covers
// back-to-back frames.
module tb_spi_master;

    localparam int TURN_P      = 2;
    localparam int FRAME_LIMIT = 60;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start2;
    logic [1:0] cmd;
    logic [7:0] wr_data;
    logic       busy, done, rd_valid, MOSI, SS_n, MISO;
    logic [7:0] rd_data;
    logic       busy2, done2, rd_valid2, mosi2, ss_n2;
    logic [7:0] rd_data2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_master #(.TURN(TURN_P), .GAP(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .wr_data(wr_data),
        .busy(busy), .done(done), .rd_data(rd_data), .rd_valid(rd_valid),
        .MOSI(MOSI), .SS_n(SS_n), .MISO(MISO)
    );

    spi_master #(.TURN(TURN_P), .GAP(2)) u_b2b (
        .clk(clk), .rst(rst), .start(start2), .cmd(cmd), .wr_data(wr_data),
        .busy(busy2), .done(done2), .rd_data(rd_data2), .rd_valid(rd_valid2),
        .MOSI(mosi2), .SS_n(ss_n2), .MISO(MISO)
    );

    // Slave/RAM model: bit j of a frame is sampled on the falling edge of
    // the j-th SS_n-low cycle; the reply for cmd=11 is driven in cycles
    // 11+TURN .. 18+TURN so the master samples it on the following rise.
    logic [7:0]  mem [0:255];
    logic [10:0] s_bits;
    logic [7:0]  s_addr;
    logic [7:0]  s_reply;
    int          s_cnt;

    always @(negedge clk) begin
        if (SS_n !== 1'b0) begin
            s_cnt = 0;
            MISO  = 1'b0;
        end else begin
            if (s_cnt <= 10) s_bits = {s_bits[9:0], MOSI};
            if (s_cnt == 10) begin
                case (s_bits[9:8])
                    2'b00:   s_addr = s_bits[7:0];
                    2'b01:   mem[s_addr] = s_bits[7:0];
                    2'b10:   s_addr = s_bits[7:0];
                    default: s_reply = mem[s_addr];
                endcase
            end
            if (s_cnt >= 11 + TURN_P && s_cnt < 19 + TURN_P)
                MISO = s_reply[18 + TURN_P - s_cnt];
            else
                MISO = 1'b0;
            s_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one frame on u_dut and watches it until busy drops. Sample i
    // is taken in cycle t+1+i where t is the accepting edge. inj_at >= 0
    // pulses a start with cmd=01 at that sample to test that it is ignored.
    task automatic run_frame(input logic [1:0] c, input logic [7:0] d, input int inj_at,
                             output int low, output int dn, output int dn_at,
                             output int rv, output int rvd, output int cyc,
                             output logic [10:0] mseq);
        start = 1'b1; cmd = c; wr_data = d;
        step();
        start = 1'b0;
        low = 0; dn = 0; dn_at = -1; rv = 0; rvd = 0; cyc = FRAME_LIMIT; mseq = '0;
        for (int i = 0; i < FRAME_LIMIT; i++) begin
            if (SS_n === 1'b0) begin
                low++;
                mseq = {mseq[9:0], MOSI};
            end
            if (done === 1'b1) begin
                dn++;
                if (dn_at < 0) dn_at = i;
            end
            if (rd_valid === 1'b1) begin
                rv++;
                if (done === 1'b1) rvd++;
            end
            if (busy === 1'b0) begin
                cyc = i;
                break;
            end
            if (i == inj_at) begin
                start = 1'b1; cmd = 2'b01; wr_data = 8'hFF;
            end else if (i == inj_at + 1) begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
    endtask

    int          low, dn, dn_at, rv, rvd, cyc;
    logic [10:0] mseq;
    logic [29:0] ss_hist;
    int          falls, f0, f1, high_run;

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0; cmd = 2'b00; wr_data = 8'h00;

        // Reset held for two edges
        step(); step();
        chk("rst_ss_n", 32'(SS_n), 32'd1);
        chk("rst_mosi", 32'(MOSI), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'h00);
        rst = 1'b0;
        step();
        chk("idle_ss_n", 32'(SS_n), 32'd1);

        // Write address 0xA5: sel 0, cmd 00, 1010_0101
        start = 1'b1; cmd = 2'b00; wr_data = 8'hA5;
        step();
        start = 1'b0;
        chk("wa_busy_t1", 32'(busy), 32'd1);
        mseq = '0; low = 0;
        for (int i = 0; i < 11; i++) begin
            if (SS_n === 1'b0) low++;
            mseq = {mseq[9:0], MOSI};
            if (done === 1'b1) chk("wa_early_done", 32'(i), 32'd99);
            step();
        end
        chk("wa_low_cycles", 32'(low), 32'd11);
        chk("wa_mosi_seq", 32'(mseq), 32'b000_1010_0101);
        chk("wa_t12_ss_n", 32'(SS_n), 32'd1);
        chk("wa_t12_done", 32'(done), 32'd1);
        chk("wa_t12_busy", 32'(busy), 32'd1);
        chk("wa_t12_rd_valid", 32'(rd_valid), 32'd0);
        step();
        chk("wa_t13_busy", 32'(busy), 32'd0);
        chk("wa_t13_done", 32'(done), 32'd0);

        // Loopback: write 0x5A to 0x12, read it back
        run_frame(2'b00, 8'h12, -1, low, dn, dn_at, rv, rvd, cyc, mseq);
        chk("lb1_wa_mosi", 32'(mseq), 32'b000_0001_0010);
        chk("lb1_wa_end", 32'(cyc), 32'd12);
        run_frame(2'b01, 8'h5A, -1, low, dn, dn_at, rv, rvd, cyc, mseq);
        chk("lb1_wd_mosi", 32'(mseq), 32'b001_0101_1010);
        chk("lb1_wd_rv", 32'(rv), 32'd0);
        run_frame(2'b10, 8'h12, -1, low, dn, dn_at, rv, rvd, cyc, mseq);
        chk("lb1_ra_mosi", 32'(mseq), 32'b110_0001_0010);
        chk("lb1_ra_low", 32'(low), 32'd11);
        run_frame(2'b11, 8'h00, -1, low, dn, dn_at, rv, rvd, cyc, mseq);
        chk("lb1_rd_data", 32'(rd_data), 32'h5A);
        chk("lb1_rd_low", 32'(low), 32'd21);
        chk("lb1_rd_done_at", 32'(dn_at), 32'd21);
        chk("lb1_rd_done_cnt", 32'(dn), 32'd1);
        chk("lb1_rd_valid_cnt", 32'(rv), 32'd1);
        chk("lb1_rd_valid_with_done", 32'(rvd), 32'd1);
        chk("lb1_rd_end", 32'(cyc), 32'd22);

        // Loopback: 0xC3 at 0xFF
        run_frame(2'b00, 8'hFF, -1, low, dn, dn_at, rv, rvd, cyc, mseq);
        run_frame(2'b01, 8'hC3, -1, low, dn, dn_at, rv, rvd, cyc, mseq);
        chk("lb2_wr_keeps_rd_data", 32'(rd_data), 32'h5A);
        run_frame(2'b10, 8'hFF, -1, low, dn, dn_at, rv, rvd, cyc, mseq);
        run_frame(2'b11, 8'h00, -1, low, dn, dn_at, rv, rvd, cyc, mseq);
        chk("lb2_rd_data", 32'(rd_data), 32'hC3);
        chk("lb2_rd_valid_with_done", 32'(rvd), 32'd1);

        // Start during SHIFT is ignored; frame is wr addr 0x3C
        run_frame(2'b00, 8'h3C, 5, low, dn, dn_at, rv, rvd, cyc, mseq);
        chk("ign_mosi", 32'(mseq), 32'b000_0011_1100);
        chk("ign_low", 32'(low), 32'd11);
        chk("ign_done_cnt", 32'(dn), 32'd1);
        chk("ign_end", 32'(cyc), 32'd12);
        low = 0;
        for (int i = 0; i < 6; i++) begin
            if (SS_n !== 1'b1 || busy !== 1'b0) low++;
            step();
        end
        chk("ign_no_extra_frame", 32'(low), 32'd0);

        // Mid-frame reset on a read-data frame
        start = 1'b1; cmd = 2'b11; wr_data = 8'h00;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("mfr_in_shift", 32'(SS_n), 32'd0);
        rst = 1'b1;
        step();
        chk("mfr_ss_n", 32'(SS_n), 32'd1);
        chk("mfr_busy", 32'(busy), 32'd0);
        chk("mfr_done", 32'(done), 32'd0);
        chk("mfr_rd_valid", 32'(rd_valid), 32'd0);
        chk("mfr_rd_data", 32'(rd_data), 32'h00);
        rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 25; i++) begin
            if (done === 1'b1 || rd_valid === 1'b1 || SS_n !== 1'b1) dn++;
            step();
        end
        chk("mfr_quiet_after", 32'(dn), 32'd0);
        run_frame(2'b00, 8'h34, -1, low, dn, dn_at, rv, rvd, cyc, mseq);
        chk("mfr_next_mosi", 32'(mseq), 32'b000_0011_0100);
        chk("mfr_next_done_at", 32'(dn_at), 32'd11);
        chk("mfr_next_end", 32'(cyc), 32'd12);
        chk("mfr_rd_data_kept", 32'(rd_data), 32'h00);

        // Back-to-back on the GAP=2 instance: 11 low + 2 END + 1 IDLE
        // accept cycle gives a 14-cycle period with SS_n high for 3 cycles.
        cmd = 2'b00; wr_data = 8'h81; start2 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            ss_hist[i] = ss_n2;
        end
        start2 = 1'b0;
        falls = 0; f0 = -1; f1 = -1; high_run = 0;
        for (int i = 0; i < 30; i++) begin
            if (ss_hist[i] === 1'b0 && (i == 0 || ss_hist[i-1] === 1'b1)) begin
                falls++;
                if (f0 < 0) f0 = i;
                else if (f1 < 0) f1 = i;
            end
            if (i < 14 && ss_hist[i] === 1'b1) high_run++;
        end
        chk("b2b_first_fall", 32'(f0), 32'd0);
        chk("b2b_period", 32'(f1 - f0), 32'd14);
        chk("b2b_frames", 32'(falls), 32'd3);
        chk("b2b_ss_high", 32'(high_run), 32'd3);
        for (int i = 0; i < 20; i++) step();
        chk("b2b_drained", 32'(busy2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
